// File: rtl/lfsr_seed_loader.sv
// Seed-pattern generator: on a user request, runs a 16-bit Fibonacci LFSR for GRID_W
// cycles, shifts its output into the grid register, then pulses lfsr_load once.
//
// state | meaning
// IDLE  | waiting for a request; lfsr_rst reloads the LFSR with SEED
// SHIFT | one LFSR step and one grid shift per cycle, GRID_W cycles total
// DONE  | lfsr_load high for this single cycle; grid and LFSR hold
// WAIT  | request still held after DONE; wait for it to drop
module lfsr_seed_loader #(
   parameter int          GRID_W = 64,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lfsr_rst,
   input  logic              en,
   input  logic              seed_req,
   output logic              lfsr_load,
   output logic              busy,
   output logic [GRID_W-1:0] grid,
   output logic [15:0]       lfsr_q
);

   localparam int                CNT_W    = $clog2(GRID_W);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(GRID_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      WAIT  = 2'd3
   } state_t;

   state_t           state;
   logic [15:0]      q;
   logic [CNT_W-1:0] cnt;
   logic             fb;

   // taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
   assign fb     = q[0] ^ q[2] ^ q[3] ^ q[5];
   assign lfsr_q = q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         q         <= SEED;
         grid      <= '0;
         cnt       <= '0;
         lfsr_load <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               lfsr_load <= 1'b0;
               // reload has priority so a held request during reload starts from SEED
               if (lfsr_rst) begin
                  q <= SEED;
               end else if (seed_req && !en) begin
                  state <= SHIFT;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               q    <= {fb, q[15:1]};
               grid <= {grid[GRID_W-2:0], q[0]};
               cnt  <= cnt + 1'b1;
               busy <= 1'b1;
               if (cnt == CNT_LAST) begin
                  state     <= DONE;
                  lfsr_load <= 1'b1;
               end
            end
            DONE: begin
               lfsr_load <= 1'b0;
               if (seed_req) begin
                  state <= WAIT;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            WAIT: begin
               lfsr_load <= 1'b0;
               if (!seed_req) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               lfsr_load <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // a zero SEED locks the LFSR at zero, which this catches on the first clock
   a_lfsr_nonzero: assert property (@(posedge clk) disable iff (reset) q != 16'h0);

endmodule

// File: tb/tb_lfsr_seed_loader.sv
// Directed bench for lfsr_seed_loader: IDLE vector table plus multi-cycle request,
// held-request, ignored en/lfsr_rst, and mid-run reset sequences against an LFSR model.
module tb_lfsr_seed_loader;

   localparam int          GW   = 64;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk, reset, lfsr_rst, en, seed_req;
   logic          lfsr_load, busy;
   logic [GW-1:0] grid;
   logic [15:0]   lfsr_q;

   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] m_state [0:200];

   typedef struct {
      string       name;
      logic        seed_req, en, lfsr_rst;
      logic        exp_busy, exp_load;
      logic [15:0] exp_q;
   } vec_t;

   vec_t vecs [7];

   lfsr_seed_loader #(.GRID_W(GW), .SEED(SEED)) dut (
      .clk       (clk),
      .reset     (reset),
      .lfsr_rst  (lfsr_rst),
      .en        (en),
      .seed_req  (seed_req),
      .lfsr_load (lfsr_load),
      .busy      (busy),
      .grid      (grid),
      .lfsr_q    (lfsr_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] model_step(input logic [15:0] s);
      logic b;
      b = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {b, s[15:1]};
   endfunction

   function automatic logic [GW-1:0] exp_grid(input int base);
      logic [GW-1:0] g;
      for (int i = 0; i < GW; i++) g[GW-1-i] = m_state[base+i][0];
      return g;
   endfunction

   // single-cycle request from IDLE; optional en / lfsr_rst raised after edge en_at / rst_at
   task automatic do_run(input int base, input int en_at, input int rst_at, input string tag);
      seed_req = 1'b1;
      step();
      chk({tag, " E0 busy"}, 64'(busy), 64'd1);
      chk({tag, " E0 load"}, 64'(lfsr_load), 64'd0);
      seed_req = 1'b0;
      for (int k = 1; k <= GW; k++) begin
         step();
         chk($sformatf("%s E%0d load", tag, k), 64'(lfsr_load), 64'(k == GW));
         chk($sformatf("%s E%0d busy", tag, k), 64'(busy), 64'd1);
         if (k == 1) chk({tag, " E1 lfsr_q"}, 64'(lfsr_q), 64'(m_state[base+1]));
         if (k == en_at)  en = 1'b1;
         if (k == rst_at) lfsr_rst = 1'b1;
      end
      chk({tag, " E64 grid"}, 64'(grid), 64'(exp_grid(base)));
      step();
      chk({tag, " E65 load"}, 64'(lfsr_load), 64'd0);
      chk({tag, " E65 busy"}, 64'(busy), 64'd0);
      chk({tag, " E65 grid"}, 64'(grid), 64'(exp_grid(base)));
      chk({tag, " E65 lfsr_q"}, 64'(lfsr_q), 64'(m_state[base+GW]));
      en       = 1'b0;
      lfsr_rst = 1'b0;
   endtask

   initial begin
      int pulses;

      m_state[0] = SEED;
      for (int i = 0; i < 200; i++) m_state[i+1] = model_step(m_state[i]);

      vecs[0] = '{"rst hold 1",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SEED};
      vecs[1] = '{"rst hold 2",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SEED};
      vecs[2] = '{"rst hold 3",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, SEED};
      vecs[3] = '{"req during rst",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, SEED};
      vecs[4] = '{"req with en 1",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SEED};
      vecs[5] = '{"req with en 2",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, SEED};
      vecs[6] = '{"all low",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, SEED};

      reset = 1'b1; lfsr_rst = 1'b0; en = 1'b0; seed_req = 1'b0;
      #1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset load", 64'(lfsr_load), 64'd0);
      chk("reset grid", 64'(grid), 64'd0);
      chk("reset lfsr_q", 64'(lfsr_q), 64'(SEED));
      step();
      step();
      reset = 1'b0;

      for (int v = 0; v < 7; v++) begin
         seed_req = vecs[v].seed_req;
         en       = vecs[v].en;
         lfsr_rst = vecs[v].lfsr_rst;
         step();
         chk({vecs[v].name, " busy"}, 64'(busy), 64'(vecs[v].exp_busy));
         chk({vecs[v].name, " load"}, 64'(lfsr_load), 64'(vecs[v].exp_load));
         chk({vecs[v].name, " lfsr_q"}, 64'(lfsr_q), 64'(vecs[v].exp_q));
         chk({vecs[v].name, " grid"}, 64'(grid), 64'd0);
      end
      chk("first step value", 64'(m_state[1]), 64'h5670);

      do_run(0, 0, 0, "run1");
      chk("run1 grid top bits", 64'(grid[GW-1:GW-2]), 64'd2);

      pulses   = 0;
      seed_req = 1'b1;
      for (int c = 0; c < 200; c++) begin
         step();
         if (lfsr_load) pulses++;
         chk($sformatf("held E%0d busy", c), 64'(busy), 64'd1);
         chk($sformatf("held E%0d load", c), 64'(lfsr_load), 64'(c == GW));
      end
      seed_req = 1'b0;
      step();
      chk("held busy after drop", 64'(busy), 64'd0);
      chk("held pulse count", 64'(pulses), 64'd1);
      chk("held grid", 64'(grid), 64'(exp_grid(GW)));
      chk("held lfsr_q", 64'(lfsr_q), 64'(m_state[2*GW]));

      lfsr_rst = 1'b1;
      step();
      lfsr_rst = 1'b0;
      chk("reload lfsr_q", 64'(lfsr_q), 64'(SEED));
      chk("reload grid kept", 64'(grid), 64'(exp_grid(GW)));

      do_run(0, 10, 20, "run_en_rst");

      lfsr_rst = 1'b1;
      step();
      lfsr_rst = 1'b0;
      seed_req = 1'b1;
      step();
      seed_req = 1'b0;
      for (int k = 1; k <= 30; k++) step();
      chk("pre-abort busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort load", 64'(lfsr_load), 64'd0);
      chk("abort grid", 64'(grid), 64'd0);
      chk("abort lfsr_q", 64'(lfsr_q), 64'(SEED));
      step();
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 70; k++) begin
         step();
         if (lfsr_load || busy) pulses++;
      end
      chk("abort no activity", 64'(pulses), 64'd0);

      do_run(0, 0, 0, "after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
